mem_wrb_stage: RTL
==================

Name: mem_wrb_stage

Overview:
- Consumer end of the MEM/WB pipeline interface.
- Latches the memory-stage outputs (control flags, PC+4, ALU result, load data, LUI immediate, destination register) into the MEM/WB register.
- Selects writeback data and drives the register-file write port exactly once per retired instruction.
- Sequences processor halt and counts retired instructions.

Parameters:
- WORD_W, 32, datapath word width.
- REG_AW, 5, register-file address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- enable  in  1  pipeline advance: latch the new MEM-side values this edge.
- flush  in  1  insert a bubble into the MEM/WB register this edge.
- valid_in  in  1  MEM side holds a real instruction.
- halt_in  in  1  MEM-side instruction is HALT.
- jALin  in  1  JAL writeback select.
- lUIin  in  1  LUI writeback select.
- memtoReg_in  in  1  load-data writeback select.
- regwr_in  in  1  instruction writes a register.
- pcplusfour_in  in  WORD_W  PC+4 of the instruction.
- alu_portOut_in  in  WORD_W  ALU result.
- data_from_mem_in  in  WORD_W  load data.
- imm_addr_for_lui_in  in  16  LUI immediate.
- dest_reg_in  in  REG_AW  destination register.
- rf_WEN  out  1  register-file write enable.
- rf_wsel  out  REG_AW  register-file write select.
- rf_wdat  out  WORD_W  register-file write data.
- wb_valid  out  1  MEM/WB register holds a real instruction.
- wb_halt  out  1  processor halted (sticky).
- retired_count  out  CNT_W  retired-instruction count.

Behaviour:
Reset (RST=1 at an edge):
- All latched fields and the written flag clear; state=RUN; retired_count=0.
- Outputs: rf_WEN=0, rf_wsel=0, rf_wdat=0, wb_valid=0, wb_halt=0.
- Reset mid-operation discards the held instruction with no write.

Latch update, evaluated each edge in state RUN only:
- flush=1: register becomes a bubble (valid=0, regwr=0, halt=0), regardless of enable. flush has priority.
- Else enable=1: capture all *_in fields; written flag clears.
- Else: hold all fields; written flag is set if a write or retire occurred in the current cycle.

Writeback data, combinational from latched fields, priority order:
- jAL: rf_wdat = pcplusfour.
- Else lUI: rf_wdat = {imm, 16'h0000}.
- Else memtoReg: rf_wdat = data_from_mem.
- Else: rf_wdat = alu_portOut.

Write-port outputs:
- rf_wsel = latched dest_reg.
- rf_WEN = valid & regwr & !halt & !written & (dest_reg != 0) & state==RUN.
- Writes to $0 are suppressed.
- A held (stalled) instruction writes only in its first cycle; no repeat writes.

Retirement:
- One retire per latched valid instruction, in its first non-written cycle, whether or not regwr is set. HALT also retires.
- retired_count increments by 1 per retire and saturates at all-ones.

State machine (RUN, DRAIN, HALTED):
- RUN -> DRAIN: at the edge where latched valid & halt & !written. HALT retires in that cycle.
- DRAIN: one cycle. rf_WEN=0; inputs ignored; latch frozen.
- DRAIN -> HALTED: unconditionally on the next edge.
- HALTED: wb_halt=1, sticky until RST. rf_WEN=0; latch, counter, and inputs frozen.
- flush and enable are ignored in DRAIN and HALTED.

Simultaneous events:
- flush on the same edge as a pending write: the write in the current cycle still occurs, because rf_WEN is combinational from current contents. The bubble loads at the edge.
- enable with the same instruction re-presented: treated as a new instruction; the producer must not re-present an instruction.

Latency:
- MEM-side values appear on rf_* one cycle after the enable edge.
- wb_halt rises two edges after the HALT latch edge.

Test Plan:
- RST=1 for 2 edges, then idle with enable=0 -> all outputs 0, retired_count=0.
- enable=1 with regwr=1, memtoReg=1, dest=5, data_from_mem=32'hDEADBEEF, ALU=32'h1234 -> next cycle rf_WEN=1, rf_wsel=5, rf_wdat=DEADBEEF; retired_count=1.
- Priority check, separate instructions: JAL with pc+4=32'h104, dest=31 -> wdat=00000104. LUI with imm=16'hABCD -> wdat=ABCD0000. Instruction with dest=0 -> rf_WEN=0, count still increments.
- Latch an instruction, then enable=0 for 3 cycles -> rf_WEN high in the first cycle only; count +1 total. Asserting flush during the hold -> next cycle wb_valid=0, rf_WEN=0.
- HALT latched after an ALU write to r3 -> r3 written, count +2. wb_halt=1 two edges after the HALT latch edge. Further enable/flush traffic is ignored: rf_WEN stays 0, count frozen.
- Assert RST while in HALTED -> wb_halt=0, retired_count=0, state RUN. The next instruction writes normally.

Source files
------------

// File: rtl/mem_wrb_stage.sv
// MEM/WB pipeline register with writeback data select, single-shot register-file write,
// retired-instruction counting and halt sequencing.
module mem_wrb_stage #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              halt_in,
  input  logic              jALin,
  input  logic              lUIin,
  input  logic              memtoReg_in,
  input  logic              regwr_in,
  input  logic [WORD_W-1:0] pcplusfour_in,
  input  logic [WORD_W-1:0] alu_portOut_in,
  input  logic [WORD_W-1:0] data_from_mem_in,
  input  logic [15:0]       imm_addr_for_lui_in,
  input  logic [REG_AW-1:0] dest_reg_in,
  output logic              rf_WEN,
  output logic [REG_AW-1:0] rf_wsel,
  output logic [WORD_W-1:0] rf_wdat,
  output logic              wb_valid,
  output logic              wb_halt,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e              state_q;
  logic                valid_q, halt_q, jal_q, lui_q, memtoreg_q, regwr_q, written_q;
  logic [WORD_W-1:0]   pc4_q, alu_q, mem_q;
  logic [15:0]         imm_q;
  logic [REG_AW-1:0]   dest_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                retire;

  // An instruction retires in the first cycle it is visible and not yet marked written.
  assign retire = (state_q == StRun) && valid_q && !written_q;

  always_comb begin
    rf_wdat = alu_q;
    if (jal_q) begin
      rf_wdat = pc4_q;
    end else if (lui_q) begin
      rf_wdat = {imm_q, 16'h0000};
    end else if (memtoreg_q) begin
      rf_wdat = mem_q;
    end
  end

  assign rf_WEN        = retire && regwr_q && !halt_q && (dest_q != '0);
  assign rf_wsel       = dest_q;
  assign wb_valid      = valid_q;
  assign wb_halt       = (state_q == StHalted);
  assign retired_count = cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StRun;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      jal_q      <= 1'b0;
      lui_q      <= 1'b0;
      memtoreg_q <= 1'b0;
      regwr_q    <= 1'b0;
      written_q  <= 1'b0;
      pc4_q      <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (retire && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (retire && halt_q) begin
            state_q <= StDrain;
          end
          if (flush) begin
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            halt_q    <= 1'b0;
            written_q <= 1'b0;
          end else if (enable) begin
            valid_q    <= valid_in;
            halt_q     <= halt_in;
            jal_q      <= jALin;
            lui_q      <= lUIin;
            memtoreg_q <= memtoReg_in;
            regwr_q    <= regwr_in;
            pc4_q      <= pcplusfour_in;
            alu_q      <= alu_portOut_in;
            mem_q      <= data_from_mem_in;
            imm_q      <= imm_addr_for_lui_in;
            dest_q     <= dest_reg_in;
            written_q  <= 1'b0;
          end else begin
            written_q <= written_q | retire;
          end
        end
        StDrain:  state_q <= StHalted;
        StHalted: state_q <= StHalted;
        default:  state_q <= StRun;
      endcase
    end
  end

endmodule
